// File: rtl/shamt_seq_shifter.sv
// shamt_seq_shifter: multicycle shift unit, one bit per cycle.
// The shift amount comes from register B, a constant, the instruction shamt
// field, or zero. The operand is latched on start and the result is held
// stable from DONE until the next accepted start.
//
// Optional feature macro: SHAMT_SEQ_SHIFTER_ROTATE_EN
//   defined   : op 11 rotates right by the selected amount.
//   undefined : op 11 forces the amount to 0, so the operand passes through.
//
// Handshake: start is sampled only in IDLE. busy is high in SHIFT and DONE.
// done is a one-cycle pulse in DONE. A start seen while busy is dropped,
// not queued.
module shamt_seq_shifter #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_W     = 5,
  parameter int CONST_SHAMT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [1:0]         shamt_src,
  input  logic [SHAMT_W-1:0] b_shamt,
  input  logic [SHAMT_W-1:0] instr_shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  localparam logic [SHAMT_W-1:0] CONST_AMT = SHAMT_W'(CONST_SHAMT);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Current FSM state. It is kept as a named signal so checkers can bind to it.
  state_t             state;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] sel_amt;
  logic [SHAMT_W-1:0] start_amt;
  logic [WIDTH-1:0]   shift_next;

  // Four-way shift-amount select.
  always_comb begin
    sel_amt = '0;
    case (shamt_src)
      2'b00:   sel_amt = b_shamt;
      2'b01:   sel_amt = CONST_AMT;
      2'b10:   sel_amt = instr_shamt;
      default: sel_amt = '0;
    endcase
  end

  // Amount latched at accept. Without rotate support, op 11 degenerates to a
  // zero-length operation.
  always_comb begin
    start_amt = sel_amt;
`ifndef SHAMT_SEQ_SHIFTER_ROTATE_EN
    if (op == 2'b11) start_amt = '0;
`endif
  end

  // One-bit step applied to the held result for the latched op.
  always_comb begin
    shift_next = result;
    case (op_q)
      OP_SLL:  shift_next = {result[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, result[WIDTH-1:1]};
      OP_SRA:  shift_next = {result[WIDTH-1], result[WIDTH-1:1]};
`ifdef SHAMT_SEQ_SHIFTER_ROTATE_EN
      default: shift_next = {result[0], result[WIDTH-1:1]};
`else
      default: shift_next = result;
`endif
    endcase
  end

  // Control FSM with registered busy/done, the held result, and the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= '0;
      op_q   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            result <= data_in;
            op_q   <= op;
            cnt    <= start_amt;
            busy   <= 1'b1;
            if (start_amt != '0) begin
              state <= S_SHIFT;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          result <= shift_next;
          cnt    <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shamt_seq_shifter.md
Name: shamt_seq_shifter

Overview:
- Parametrised multicycle shift unit for the datapath. It merges shift-amount source selection with an iterative one-bit-per-cycle shifter.
- Shift amount is selected from register B, a constant, or the instruction shamt field (4-way select).
- Data operand is latched on start; the result is held stable after done.
- Sits between the register file / instruction register and the ALU-out mux, and is driven by the control FSM through a start/busy/done handshake.

Parameters:
- WIDTH, 32, data width in bits (>= 2).
- SHAMT_W, 5, shift-amount width; must equal $clog2(WIDTH).
- CONST_SHAMT, 16, constant amount used when shamt_src = 01; must be < WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature).
- shamt_src  in  2  00 b_shamt, 01 CONST_SHAMT, 10 instr_shamt, 11 zero.
- b_shamt  in  SHAMT_W  shift amount from register B (low bits).
- instr_shamt  in  SHAMT_W  shift amount from instruction field.
- data_in  in  WIDTH  operand to shift.
- result  out  WIDTH  shifted value.
- busy  out  1  unit occupied.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, applied synchronously at the clk edge while reset=1:
  - state=IDLE, result=0, busy=0, done=0, internal counter=0.
  - Reset wins over every other input, including mid-operation; any in-flight shift is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On a clk edge with start=1:
    - latch data_in into result.
    - latch op.
    - latch selected amount into cnt (shamt_src 11 -> 0).
  - Next state is SHIFT if cnt != 0, else DONE.
  - start=0 -> stay in IDLE; result holds.
- SHIFT:
  - busy=1.
  - Each cycle, shift result by one bit and decrement cnt.
    - SLL: shift left, zero fill.
    - SRL: shift right, zero fill.
    - SRA: shift right, replicate MSB.
  - When cnt reaches 1 in the current cycle (last shift performed), go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - Next state is IDLE; result holds.
- Latency: for amount N, done is high in cycle N+1 after the start edge (N=0 -> done on the cycle after start). Total occupancy is N+1 cycles.
- start while busy=1 (SHIFT or DONE) is ignored; it is not queued. A start in the cycle after DONE (IDLE) is accepted.
- Inputs other than start are sampled only at the accept edge; later changes have no effect on the operation in flight.
- Amount width: all sources are SHAMT_W bits, so the maximum is WIDTH-1. No amount >= WIDTH is possible.
- result changes only at the accept edge and during SHIFT; it is stable from DONE until the next accepted start.

Optional Feature:
- Macro: SHAMT_SEQ_SHIFTER_ROTATE_EN.
- Defined: op 11 = rotate right; each SHIFT cycle moves the LSB into the MSB. Same latency rules as the other ops.
- Undefined: op 11 forces the latched amount to 0. result = data_in unchanged; done asserts on the cycle after start (1-cycle occupancy).

Test Plan:
- Reset mid-shift: start SLL, data 0x0000_0001, amount 16 via shamt_src=01; assert reset at cycle 5 -> next cycle result=0, busy=0, done=0, state IDLE, no done pulse afterwards.
- SLL via constant: data 0x0000_00FF, shamt_src=01 -> done in cycle 17, result=0x00FF_0000, busy high for cycles 1..17.
- SRA via b_shamt: data 0x8000_0000, b_shamt=4, op=10 -> done in cycle 5, result=0xF800_0000. Same with op=01 -> result=0x0800_0000.
- Zero-amount path: shamt_src=11 (or instr_shamt=0), data 0x1234_5678 -> done in cycle 1, result=0x1234_5678.
- Start while busy: SRL, instr_shamt=3, data 0x0000_0080; pulse start again in cycle 2 with different data -> ignored, result=0x0000_0010 at done in cycle 4. Start in cycle 5 is accepted.
- op=11, data 0x0000_0001, b_shamt=1:
  - with SHAMT_SEQ_SHIFTER_ROTATE_EN -> result=0x8000_0000, done in cycle 2.
  - without it -> result=0x0000_0001, done in cycle 1.
